// File: rtl/aes_simd_pkg.sv
// Shared decode constants, FSM state encoding and the decoded-instruction payload.
package aes_simd_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 5;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned NREGS   = 32;
    localparam int unsigned CNT_W   = 10;

    // Instruction bit 0 is the MSB, so instr[0:4] lives in vector bits 31:27.
    localparam int unsigned OPC_HI  = 31;
    localparam int unsigned OPC_LO  = 27;
    localparam int unsigned RD_HI   = 26;
    localparam int unsigned RD_LO   = 22;
    localparam int unsigned RS_HI   = 21;
    localparam int unsigned RS_LO   = 17;
    localparam int unsigned IMM8_HI = 7;
    localparam int unsigned IMM8_LO = 0;

    localparam logic [OPC_W-1:0] OP_IMM8 = 5'b11000;
    localparam logic [OPC_W-1:0] OP_IMM5 = 5'b11001;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b00000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        VWAIT = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic [OPC_W-1:0]   opcode;
        logic [REG_W-1:0]   rd;
        logic [REG_W-1:0]   rs;
        logic [INSTR_W-1:0] imm;
        logic               vec;
        logic               writes_rd;
    } dec_t;

    // Field extraction, immediate selection and op class for one instruction.
    function automatic dec_t decode(input logic [INSTR_W-1:0] instr);
        dec_t d;
        d.opcode = instr[OPC_HI:OPC_LO];
        d.rd     = instr[RD_HI:RD_LO];
        d.rs     = instr[RS_HI:RS_LO];
        case (d.opcode)
            OP_IMM8: d.imm = INSTR_W'(instr[IMM8_HI:IMM8_LO]);
            OP_IMM5: d.imm = INSTR_W'(instr[RS_HI:RS_LO]);
            default: d.imm = '0;
        endcase
        // opcode[0:1] in MSB-first numbering is opcode[4:3] here.
        d.vec       = (d.opcode[4:3] == 2'b10);
        d.writes_rd = (d.opcode != OP_NOP) && (d.opcode[4:3] != 2'b01);
        return d;
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Pending-write bit per architectural register, with two combinational read ports.
module decode_scoreboard
    import aes_simd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en_i,
    input  logic [REG_W-1:0] set_idx_i,
    input  logic             clr_en_i,
    input  logic [REG_W-1:0] clr_idx_i,
    input  logic [REG_W-1:0] rs_idx_i,
    input  logic [REG_W-1:0] rd_idx_i,
    output logic             rs_busy_c_o,
    output logic             rd_busy_c_o
);

    logic [NREGS-1:0] sb_q, sb_d;

    // Clear first so a same-cycle set of the same register wins; r0 never pends.
    always_comb begin
        sb_d = sb_q;
        if (clr_en_i) sb_d[clr_idx_i] = 1'b0;
        if (set_en_i) sb_d[set_idx_i] = 1'b1;
        sb_d[0] = 1'b0;
    end

    // Pending vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sb_q <= '0;
        else        sb_q <= sb_d;
    end

    assign rs_busy_c_o = sb_q[rs_idx_i];
    assign rd_busy_c_o = sb_q[rd_idx_i];

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode/issue controller: holds one instruction until its registers are free,
// issues it with valid/ready, and sequences SIMD ops until done or timeout.
module decode_issue_ctrl
    import aes_simd_pkg::*;
#(
    parameter int unsigned VEC_TIMEOUT = 255
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               iss_valid,
    input  logic               iss_ready,
    output logic [OPC_W-1:0]   iss_opcode,
    output logic [REG_W-1:0]   iss_rd,
    output logic [REG_W-1:0]   iss_rs,
    output logic [INSTR_W-1:0] iss_imm,
    output logic               iss_vec,
    input  logic               vec_done,
    input  logic               wb_valid,
    input  logic [REG_W-1:0]   wb_rd,
    input  logic               flush,
    output logic               vec_timeout
);

    ctrl_state_t        state_q, state_d;
    logic [INSTR_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               vto_q, vto_d;
    dec_t               dec;
    logic               rs_busy_c, rd_busy_c, hazard_c, fire_c, sb_set_c;

    assign dec      = decode(hold_q);
    assign hazard_c = rs_busy_c | (dec.writes_rd & rd_busy_c);
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign sb_set_c = fire_c && dec.writes_rd && (dec.rd != '0);

    decode_scoreboard u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_en_i    (sb_set_c),
        .set_idx_i   (dec.rd),
        .clr_en_i    (wb_valid),
        .clr_idx_i   (wb_rd),
        .rs_idx_i    (dec.rs),
        .rd_idx_i    (dec.rd),
        .rs_busy_c_o (rs_busy_c),
        .rd_busy_c_o (rd_busy_c)
    );

    // Next-state, handshake and counter logic; flush beats a same-cycle fire.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        vto_d     = vto_q;
        in_ready  = 1'b0;
        iss_valid = 1'b0;
        fire_c    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    hold_d  = in_instr;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                iss_valid = !hazard_c && !flush;
                fire_c    = iss_valid && iss_ready;
                if (flush) begin
                    hold_d  = '0;
                    state_d = IDLE;
                end else if (fire_c) begin
                    if (dec.vec) begin
                        cnt_d   = '0;
                        state_d = VWAIT;
                    end else begin
                        in_ready = 1'b1;
                        if (in_valid) hold_d  = in_instr;
                        else          state_d = IDLE;
                    end
                end
            end
            VWAIT: begin
                cnt_d = cnt_inc;
                if (vec_done) begin
                    state_d = IDLE;
                end else if (cnt_inc == CNT_W'(VEC_TIMEOUT)) begin
                    vto_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state, hold register, VWAIT counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
            vto_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            vto_q   <= vto_d;
        end
    end

    assign iss_opcode  = dec.opcode;
    assign iss_rd      = dec.rd;
    assign iss_rs      = dec.rs;
    assign iss_imm     = dec.imm;
    assign iss_vec     = dec.vec;
    assign vec_timeout = vto_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl with VEC_TIMEOUT=8.
module tb_decode_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, iss_valid, iss_ready, iss_vec;
    logic        vec_done, wb_valid, flush, vec_timeout;
    logic [31:0] in_instr, iss_imm;
    logic [4:0]  iss_opcode, iss_rd, iss_rs, wb_rd;
    int          total = 0;
    int          bad   = 0;

    decode_issue_ctrl #(.VEC_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_opcode(iss_opcode), .iss_rd(iss_rd), .iss_rs(iss_rs),
        .iss_imm(iss_imm), .iss_vec(iss_vec), .vec_done(vec_done),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .vec_timeout(vec_timeout)
    );

    always #5 clk = ~clk;

    // opcode=instr[0:4], rd=instr[5:9], rs=instr[10:14], low byte=instr[24:31]
    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [7:0] lo);
        return {op, rd, rs, 9'd0, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wb(input logic [4:0] r);
        wb_valid = 1'b1;
        wb_rd    = r;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_instr = mk(5'b11000, 5'd1, 5'd2, 8'h77);
        iss_ready = 1'b0; vec_done = 1'b0; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL rst_hold_iss_valid got=%0h exp=0", iss_valid); end
        rst_n = 1'b1; in_valid = 1'b0; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
        total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL rst_iss_valid got=%0h exp=0", iss_valid); end
        total++; if (vec_timeout !== 1'b0) begin bad++; $display("FAIL rst_vec_timeout got=%0h exp=0", vec_timeout); end
        total++; if (iss_imm !== 32'h0) begin bad++; $display("FAIL rst_iss_imm got=%0h exp=0", iss_imm); end
        total++; if (iss_opcode !== 5'h0) begin bad++; $display("FAIL rst_iss_opcode got=%0h exp=0", iss_opcode); end
        tick();
    endtask

    task automatic test_imm();
        in_valid = 1'b1; in_instr = mk(5'b11000, 5'd3, 5'd4, 8'hA5); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL imm8_in_ready got=%0h exp=1", in_ready); end
        tick(); in_valid = 1'b0; iss_ready = 1'b0; #1;
        total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL imm8_iss_valid got=%0h exp=1", iss_valid); end
        total++; if (iss_imm !== 32'h000000A5) begin bad++; $display("FAIL imm8_value got=%0h exp=a5", iss_imm); end
        total++; if (iss_opcode !== 5'b11000) begin bad++; $display("FAIL imm8_opcode got=%0h exp=18", iss_opcode); end
        total++; if (iss_rd !== 5'd3) begin bad++; $display("FAIL imm8_rd got=%0d exp=3", iss_rd); end
        total++; if (iss_rs !== 5'd4) begin bad++; $display("FAIL imm8_rs got=%0d exp=4", iss_rs); end
        total++; if (iss_vec !== 1'b0) begin bad++; $display("FAIL imm8_vec got=%0h exp=0", iss_vec); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL imm8_stall_in_ready got=%0h exp=0", in_ready); end
        tick(); #1;
        total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL imm8_stable_valid got=%0h exp=1", iss_valid); end
        total++; if (iss_imm !== 32'h000000A5) begin bad++; $display("FAIL imm8_stable_imm got=%0h exp=a5", iss_imm); end
        iss_ready = 1'b1; tick(); iss_ready = 1'b0; #1;
        total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL imm8_idle_valid got=%0h exp=0", iss_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL imm8_idle_ready got=%0h exp=1", in_ready); end
        do_wb(5'd3);
        in_valid = 1'b1; in_instr = mk(5'b11001, 5'd5, 5'd31, 8'h00);
        tick(); in_valid = 1'b0; iss_ready = 1'b1; #1;
        total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL imm5_iss_valid got=%0h exp=1", iss_valid); end
        total++; if (iss_imm !== 32'h0000001F) begin bad++; $display("FAIL imm5_value got=%0h exp=1f", iss_imm); end
        tick(); iss_ready = 1'b0;
        do_wb(5'd5);
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_instr = mk(5'b00001, 5'd1, 5'd0, 8'hFF); iss_ready = 1'b1; tick();
        in_instr = mk(5'b00001, 5'd2, 5'd0, 8'hFF); #1;
        total++; if (iss_valid !== 1'b1 || iss_rd !== 5'd1) begin bad++; $display("FAIL b2b_first got=%0h/%0d exp=1/1", iss_valid, iss_rd); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_bypass1 got=%0h exp=1", in_ready); end
        total++; if (iss_imm !== 32'h0) begin bad++; $display("FAIL b2b_imm_zero got=%0h exp=0", iss_imm); end
        tick(); in_instr = mk(5'b00001, 5'd4, 5'd0, 8'h00); #1;
        total++; if (iss_valid !== 1'b1 || iss_rd !== 5'd2) begin bad++; $display("FAIL b2b_second got=%0h/%0d exp=1/2", iss_valid, iss_rd); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_bypass2 got=%0h exp=1", in_ready); end
        tick(); in_valid = 1'b0; #1;
        total++; if (iss_valid !== 1'b1 || iss_rd !== 5'd4) begin bad++; $display("FAIL b2b_third got=%0h/%0d exp=1/4", iss_valid, iss_rd); end
        tick(); iss_ready = 1'b0; #1;
        total++; if (iss_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%0h/%0h exp=0/1", iss_valid, in_ready); end
        do_wb(5'd1); do_wb(5'd2); do_wb(5'd4);
    endtask

    task automatic test_hazard();
        in_valid = 1'b1; in_instr = mk(5'b00001, 5'd7, 5'd0, 8'h00); iss_ready = 1'b1; tick();
        in_instr = mk(5'b00001, 5'd8, 5'd7, 8'h00); #1;
        total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL haz_producer got=%0h exp=1", iss_valid); end
        tick(); in_valid = 1'b0; #1;
        total++; if (iss_valid !== 1'b0 || iss_rs !== 5'd7) begin bad++; $display("FAIL haz_blocked got=%0h/%0d exp=0/7", iss_valid, iss_rs); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL haz_in_ready got=%0h exp=0", in_ready); end
        tick(); wb_valid = 1'b1; wb_rd = 5'd7; #1;
        total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL haz_wb_cycle got=%0h exp=0", iss_valid); end
        tick(); wb_valid = 1'b0; #1;
        total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL haz_released got=%0h exp=1", iss_valid); end
        tick(); iss_ready = 1'b0; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL haz_idle got=%0h exp=1", in_ready); end
        do_wb(5'd8);
    endtask

    task automatic test_writes_rd();
        in_valid = 1'b1; in_instr = mk(5'b01000, 5'd9, 5'd0, 8'h00); iss_ready = 1'b1; tick();
        in_instr = mk(5'b00001, 5'd9, 5'd9, 8'h00); #1;
        total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL wr_store_issue got=%0h exp=1", iss_valid); end
        tick(); in_valid = 1'b0; #1;
        total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL wr_no_pend got=%0h exp=1", iss_valid); end
        tick(); in_valid = 1'b1; in_instr = mk(5'b00010, 5'd9, 5'd0, 8'h00);
        tick(); in_valid = 1'b0; #1;
        total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL wr_rd_hazard got=%0h exp=0", iss_valid); end
        do_wb(5'd9); #1;
        total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL wr_rd_release got=%0h exp=1", iss_valid); end
        tick(); iss_ready = 1'b0;
        do_wb(5'd9);
    endtask

    task automatic test_vec_done();
        in_valid = 1'b1; in_instr = mk(5'b10000, 5'd10, 5'd0, 8'h00); iss_ready = 1'b1; tick();
        in_valid = 1'b0; #1;
        total++; if (iss_valid !== 1'b1 || iss_vec !== 1'b1) begin bad++; $display("FAIL vd_issue got=%0h/%0h exp=1/1", iss_valid, iss_vec); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL vd_fire_in_ready got=%0h exp=0", in_ready); end
        tick(); in_valid = 1'b1; in_instr = mk(5'b00001, 5'd1, 5'd0, 8'h00);
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) vec_done = 1'b1;
            #1;
            total++; if (in_ready !== 1'b0 || iss_valid !== 1'b0) begin bad++; $display("FAIL vd_wait_%0d got=%0h/%0h exp=0/0", k, in_ready, iss_valid); end
            tick();
        end
        vec_done = 1'b0; in_valid = 1'b0; iss_ready = 1'b0; #1;
        total++; if (in_ready !== 1'b1 || iss_valid !== 1'b0) begin bad++; $display("FAIL vd_idle got=%0h/%0h exp=1/0", in_ready, iss_valid); end
        total++; if (vec_timeout !== 1'b0) begin bad++; $display("FAIL vd_no_timeout got=%0h exp=0", vec_timeout); end
        do_wb(5'd10);
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_instr = mk(5'b00001, 5'd12, 5'd0, 8'h00); iss_ready = 1'b0; tick();
        in_instr = mk(5'b00001, 5'd14, 5'd0, 8'h00); iss_ready = 1'b1; flush = 1'b1; #1;
        total++; if (iss_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL fl_cycle got=%0h/%0h exp=0/0", iss_valid, in_ready); end
        tick(); flush = 1'b0; in_valid = 1'b0; #1;
        total++; if (in_ready !== 1'b1 || iss_valid !== 1'b0) begin bad++; $display("FAIL fl_after got=%0h/%0h exp=1/0", in_ready, iss_valid); end
        in_valid = 1'b1; flush = 1'b1; in_instr = mk(5'b00001, 5'd13, 5'd12, 8'h00); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fl_idle_ready got=%0h exp=1", in_ready); end
        tick(); flush = 1'b0; in_valid = 1'b0; #1;
        total++; if (iss_valid !== 1'b1 || iss_rs !== 5'd12 || iss_rd !== 5'd13) begin bad++; $display("FAIL fl_sb_clean got=%0h/%0d/%0d exp=1/12/13", iss_valid, iss_rs, iss_rd); end
        tick(); iss_ready = 1'b0;
        do_wb(5'd13);
    endtask

    task automatic test_vec_timeout();
        in_valid = 1'b1; in_instr = mk(5'b10001, 5'd11, 5'd0, 8'h00); iss_ready = 1'b1; tick();
        in_valid = 1'b0; #1;
        total++; if (iss_valid !== 1'b1 || iss_vec !== 1'b1) begin bad++; $display("FAIL vt_issue got=%0h/%0h exp=1/1", iss_valid, iss_vec); end
        tick(); iss_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            total++; if (vec_timeout !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL vt_wait_%0d got=%0h/%0h exp=0/0", k, vec_timeout, in_ready); end
            tick();
        end
        #1;
        total++; if (vec_timeout !== 1'b1) begin bad++; $display("FAIL vt_flag got=%0h exp=1", vec_timeout); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL vt_idle got=%0h exp=1", in_ready); end
        vec_done = 1'b1; tick(); vec_done = 1'b0; tick(); #1;
        total++; if (vec_timeout !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL vt_sticky got=%0h/%0h exp=1/1", vec_timeout, in_ready); end
        do_wb(5'd11);
    endtask

    initial begin
        test_reset();
        test_imm();
        test_back_to_back();
        test_hazard();
        test_writes_rd();
        test_vec_done();
        test_flush();
        test_vec_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/decode_issue_ctrl.md
# decode_issue_ctrl

Decode/issue stage controller between instruction fetch and the scalar and SIMD (AES) execution units. It accepts one 32-bit instruction at a time, extracts register fields and the zero-extended immediate, and holds the instruction until its source and destination registers are free of pending writes. It then issues the instruction with a valid/ready handshake. Vector ops are sequenced as multi-cycle operations: issue blocks until the SIMD unit reports completion or a timeout fires.

## Interface
Parameters:
- VEC_TIMEOUT, 255: cycles allowed in VWAIT before abort; legal range 1..1023.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- in_valid  in  1  fetch presents in_instr
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction, bit 0 = MSB
- iss_valid  out  1  issue request
- iss_ready  in  1  execution unit accepts
- iss_opcode  out  5  instr[0:4]
- iss_rd  out  5  instr[5:9]
- iss_rs  out  5  instr[10:14]
- iss_imm  out  32  decoded immediate
- iss_vec  out  1  opcode[0:1]==2'b10 (SIMD op)
- vec_done  in  1  SIMD unit completion pulse
- wb_valid  in  1  register writeback
- wb_rd  in  5  writeback register
- flush  in  1  discard the held instruction
- vec_timeout  out  1  sticky error flag

## Operation
- Immediate decoding:
  - Opcode 5'b11000: iss_imm = zero-extended instr[24:31].
  - Opcode 5'b11001: iss_imm = zero-extended instr[10:14].
  - All other opcodes: iss_imm = 0.
- writes_rd = (opcode != 5'b00000) && (opcode[0:1] != 2'b01).
- FSM states IDLE, HOLD, VWAIT:
  - IDLE: in_ready=1. in_valid captures in_instr into the hold register and moves to HOLD.
  - HOLD:
    - hazard = sb[rs] | (writes_rd & sb[rd]).
    - iss_valid = !hazard.
    - fire = iss_valid & iss_ready.
    - On fire of a scalar op: go to IDLE.
    - In the same cycle, in_ready=1 (bypass), so a new in_valid captures directly and the FSM stays in HOLD.
    - On fire of a vector op: go to VWAIT; in_ready=0.
  - VWAIT: iss_valid=0, in_ready=0. Cycle counter runs.
    - vec_done goes to IDLE.
    - Counter == VEC_TIMEOUT sets vec_timeout and goes to IDLE.
- Scoreboard: 32 pending bits.
  - On fire with writes_rd and rd!=0, set sb[rd].
  - wb_valid clears sb[wb_rd].
  - Same register set and cleared in one cycle: set wins.
  - sb[0] is always 0.
- Boundary conditions:
  - flush in HOLD drops the hold register, goes to IDLE, and forces in_ready=0 that cycle.
  - flush in IDLE/VWAIT is ignored; the scoreboard is unaffected.
  - flush and fire in the same cycle: flush wins and no issue occurs.
  - vec_done outside VWAIT is ignored.
  - vec_timeout clears only on reset.
- Issue outputs are driven from the hold register and are stable while iss_valid=1 and iss_ready=0.

## Timing
- Reset (async assert, sync release):
  - State=IDLE; scoreboard, hold register and counter cleared.
  - Outputs: in_ready=1; all other outputs 0.
- Latency: accepted at edge N, iss_valid high in cycle N+1 if there is no hazard.
- Throughput: one scalar instruction per cycle with bypass.
- Vector op: issue cycle plus ≥1 VWAIT cycle.
- Hazard is evaluated on the registered scoreboard. A wb_valid in cycle N unblocks issue in cycle N+1.
- Counter is 10 bits, reset on VWAIT entry, saturating.

## Structure
- Shared package aes_simd_pkg holds:
  - Opcode constants OP_IMM8=5'b11000, OP_IMM5=5'b11001, OP_NOP=5'b00000.
  - Field position constants.
  - Enum ctrl_state_t {IDLE, HOLD, VWAIT}.
- Sub-module decode_scoreboard holds the 32-bit pending vector with set/clear ports and two combinational read ports (rs, rd).

## Test plan
- Reset with in_valid=1 → after release, in_ready=1, iss_valid=0, vec_timeout=0, iss_imm=0.
- in_instr with opcode 11000, instr[24:31]=8'hA5 → next cycle iss_valid=1, iss_imm=32'h000000A5. Same test with opcode 11001, instr[10:14]=5'h1F → iss_imm=32'h0000001F.
- Back-to-back scalar ops with iss_ready=1 → one issue per cycle.
- Second instruction reads the first's rd → held until wb_valid for that rd; iss_valid rises the following cycle.
- Vector op (opcode 10xxx):
  - vec_done after 5 cycles → in_ready=0 throughout, IDLE after vec_done.
  - With VEC_TIMEOUT=8 and no vec_done → vec_timeout=1 after 8 VWAIT cycles and the FSM returns to IDLE.
- flush asserted together with iss_ready in HOLD → no issue, scoreboard unchanged, in_ready=1 the cycle after.
